risc_stack_unit: RTL and testbench

Parametrised hardware stack for the risc8 core family, serving PUSH/POP and multi-byte CALL/RET/RETI return-address storage. It is generalised in word width, depth and return-address width. It adds over/underflow detection, a replace-top mode, and a sequenced multi-word call/return engine with a busy handshake. It sits beside the datapath and is driven by control through `e_stackop` plus call/return strobes.

---
 rtl/risc8_pkg.sv | 25 ++
 rtl/risc_stack_unit_if.sv | 37 +++
 rtl/risc_stack_mem.sv | 30 +++
 rtl/risc_stack_unit.sv | 209 ++++++++++++++++++++
 tb/tb_risc_stack_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc8_pkg.sv
// rtl/risc8_pkg.sv - shared types and defaults for the risc8 stack unit
// Contents:
//   e_stackop     : single-word stack operation selected by control
//   e_stack_state : call/return sequencer states
//   STACK_DEPTH   : default number of stack entries
//   PC_BYTES      : default number of words per return address
package risc8_pkg;

  typedef enum logic [1:0] {
    ST_SKIP = 2'd0,
    ST_ADD  = 2'd1,
    ST_SUB  = 2'd2,
    ST_3    = 2'd3
  } e_stackop;

  typedef enum logic [1:0] {
    SS_IDLE = 2'd0,
    SS_CALL = 2'd1,
    SS_RET  = 2'd2
  } e_stack_state;

  localparam int STACK_DEPTH = 16;
  localparam int PC_BYTES    = 2;

endpackage

// File: rtl/risc_stack_unit_if.sv
// rtl/risc_stack_unit_if.sv - control/data bundle between the risc8 core and its stack unit
// master (core side) drives: op, wdata, call_req, call_pc, ret_req, clr_err
// slave (stack side) drives: rdata, ret_pc, ret_valid, busy, count, full, empty, ovf, udf
interface risc_stack_unit_if #(
  parameter int WORD     = 8,
  parameter int DEPTH    = risc8_pkg::STACK_DEPTH,
  parameter int PC_BYTES = risc8_pkg::PC_BYTES
);
  import risc8_pkg::*;

  e_stackop                     op;
  logic [WORD-1:0]              wdata;
  logic [WORD-1:0]              rdata;
  logic                         call_req;
  logic [WORD*PC_BYTES-1:0]     call_pc;
  logic                         ret_req;
  logic [WORD*PC_BYTES-1:0]     ret_pc;
  logic                         ret_valid;
  logic                         busy;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         full;
  logic                         empty;
  logic                         ovf;
  logic                         udf;
  logic                         clr_err;

  modport master (
    output op, wdata, call_req, call_pc, ret_req, clr_err,
    input  rdata, ret_pc, ret_valid, busy, count, full, empty, ovf, udf
  );

  modport slave (
    input  op, wdata, call_req, call_pc, ret_req, clr_err,
    output rdata, ret_pc, ret_valid, busy, count, full, empty, ovf, udf
  );

endinterface

// File: rtl/risc_stack_mem.sv
// rtl/risc_stack_mem.sv - WORD x DEPTH stack storage, synchronous write, asynchronous read
// Ports:
//   clk   : write clock
//   we    : write enable, waddr/wdata captured on the rising edge
//   raddr : combinational read address, rdata follows it directly
// Contents are deliberately not reset.
module risc_stack_mem #(
  parameter int WORD  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [WORD-1:0] rdata
);

  logic [WORD-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/risc_stack_unit.sv
// rtl/risc_stack_unit.sv - risc8 hardware stack with push/pop/replace and multi-word call/return
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : risc_stack_unit_if.slave (op/wdata/call/ret/clr_err in; rdata/ret_pc/ret_valid/
//           busy/count/full/empty/ovf/udf out)
module risc_stack_unit #(
  parameter int WORD     = 8,
  parameter int DEPTH    = risc8_pkg::STACK_DEPTH,
  parameter int PC_BYTES = risc8_pkg::PC_BYTES
) (
  input logic              clk,
  input logic              rst_n,
  risc_stack_unit_if.slave bus
);
  import risc8_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = (PC_BYTES > 1) ? $clog2(PC_BYTES) : 1;
  localparam int PW = WORD * PC_BYTES;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  // A call fits while DEPTH-count >= PC_BYTES, i.e. count <= DEPTH-PC_BYTES.
  localparam logic [CW-1:0] CALL_MAX = CW'(DEPTH - PC_BYTES);
  localparam logic [CW-1:0] PCB_C    = CW'(PC_BYTES);
  localparam logic [KW-1:0] K_LAST   = KW'(PC_BYTES - 1);

  e_stack_state  state;
  logic [KW-1:0] k;
  logic [CW-1:0] count;
  logic          busy;
  logic          ovf;
  logic          udf;
  logic          ret_valid;
  logic [PW-1:0] call_q;
  logic [PW-1:0] ret_acc;
  logic [PW-1:0] ret_acc_next;
  logic [PW-1:0] ret_pc;

  logic          full;
  logic          empty;
  logic          idle;
  logic          call_fits;
  logic          ret_fits;
  logic          take_call;
  logic          take_ret;
  logic          take_op;
  logic          set_ovf;
  logic          set_udf;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [WORD-1:0] mem_wdata;
  logic [AW-1:0]   top_addr;
  logic [WORD-1:0] top_word;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign idle      = (state == SS_IDLE);
  assign call_fits = (count <= CALL_MAX);
  assign ret_fits  = (count >= PCB_C);

  // Strict priority in IDLE: call, then return, then the single-word op.
  assign take_call = idle & bus.call_req;
  assign take_ret  = idle & ~bus.call_req & bus.ret_req;
  assign take_op   = idle & ~bus.call_req & ~bus.ret_req;

  // Top-of-stack address; wraps harmlessly when empty because rdata is masked.
  assign top_addr  = AW'(count - CW'(1));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = AW'(count);
    mem_wdata = bus.wdata;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;

    if (take_call && !call_fits) set_ovf = 1'b1;
    if (take_ret && !ret_fits)   set_udf = 1'b1;

    if (take_op) begin
      case (bus.op)
        ST_ADD: begin
          if (full) set_ovf = 1'b1;
          else      mem_we  = 1'b1;
        end
        ST_SUB: begin
          if (empty) set_udf = 1'b1;
        end
        ST_3: begin
          if (empty) begin
            set_udf = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = top_addr;
          end
        end
        default: ;
      endcase
    end

    // Call sequence pushes the latched address LSB first.
    if (state == SS_CALL) begin
      mem_we    = 1'b1;
      mem_wdata = call_q[int'(k)*WORD +: WORD];
    end
  end

  // Return sequence pops MSB first, so pop k fills byte PC_BYTES-1-k.
  always_comb begin
    ret_acc_next = ret_acc;
    ret_acc_next[(PC_BYTES-1-int'(k))*WORD +: WORD] = top_word;
  end

  risc_stack_mem #(
    .WORD  (WORD),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (top_addr),
    .rdata (top_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SS_IDLE;
      k         <= '0;
      count     <= '0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      ret_valid <= 1'b0;
      ret_pc    <= '0;
      ret_acc   <= '0;
      call_q    <= '0;
    end else begin
      // A new error in the same cycle as clr_err leaves the flag set.
      ovf       <= set_ovf | (ovf & ~bus.clr_err);
      udf       <= set_udf | (udf & ~bus.clr_err);
      ret_valid <= 1'b0;

      case (state)
        SS_IDLE: begin
          k <= '0;
          if (bus.call_req) begin
            if (call_fits) begin
              call_q <= bus.call_pc;
              state  <= SS_CALL;
              busy   <= 1'b1;
            end
          end else if (bus.ret_req) begin
            if (ret_fits) begin
              state <= SS_RET;
              busy  <= 1'b1;
            end
          end else if (bus.op == ST_ADD && !full) begin
            count <= count + CW'(1);
          end else if (bus.op == ST_SUB && !empty) begin
            count <= count - CW'(1);
          end
        end

        SS_CALL: begin
          count <= count + CW'(1);
          if (k == K_LAST) begin
            state <= SS_IDLE;
            busy  <= 1'b0;
          end else begin
            k <= k + KW'(1);
          end
        end

        SS_RET: begin
          count   <= count - CW'(1);
          ret_acc <= ret_acc_next;
          if (k == K_LAST) begin
            ret_pc    <= ret_acc_next;
            ret_valid <= 1'b1;
            state     <= SS_IDLE;
            busy      <= 1'b0;
          end else begin
            k <= k + KW'(1);
          end
        end

        default: begin
          state <= SS_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata     = empty ? '0 : top_word;
  assign bus.ret_pc    = ret_pc;
  assign bus.ret_valid = ret_valid;
  assign bus.busy      = busy;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.ovf       = ovf;
  assign bus.udf       = udf;

endmodule

// File: tb/tb_risc_stack_unit.sv
// tb/tb_risc_stack_unit.sv - self-checking bench for risc_stack_unit (WORD=8, DEPTH=4, PC_BYTES=2)
module tb_risc_stack_unit;
  import risc8_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  risc_stack_unit_if #(.WORD(W), .DEPTH(D), .PC_BYTES(P)) bus();

  risc_stack_unit #(.WORD(W), .DEPTH(D), .PC_BYTES(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the stack as a queue, top at the back.
  logic [7:0]  stk[$];
  bit          m_ovf;
  bit          m_udf;
  logic [15:0] m_ret_pc;

  function automatic logic [14:0] exp_status();
    int n;
    logic [7:0] top;
    n   = stk.size();
    top = (n == 0) ? 8'h00 : stk[n-1];
    return {3'(n), (n == D), (n == 0), m_ovf, m_udf, top};
  endfunction

  function automatic logic [14:0] obs_status();
    return {bus.count, bus.full, bus.empty, bus.ovf, bus.udf, bus.rdata};
  endfunction

  task automatic model_reset();
    stk.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_ret_pc = 16'h0000;
  endtask

  task automatic idle_inputs();
    bus.op       = ST_SKIP;
    bus.wdata    = 8'h00;
    bus.call_req = 1'b0;
    bus.call_pc  = 16'h0000;
    bus.ret_req  = 1'b0;
    bus.clr_err  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drives one request cycle and advances the model by its architectural effect.
  task automatic apply(input e_stackop o, input logic [7:0] d, input bit c, input logic [15:0] pc,
                       input bit r, input bit clr, output int nbusy, output bit exp_rv);
    bus.op = o; bus.wdata = d; bus.call_req = c; bus.call_pc = pc;
    bus.ret_req = r; bus.clr_err = clr;
    @(posedge clk); #1;
    idle_inputs();
    nbusy  = 0;
    exp_rv = 1'b0;
    if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (c) begin
      if (D - stk.size() >= P) begin
        stk.push_back(pc[7:0]); stk.push_back(pc[15:8]); nbusy = P;
      end else m_ovf = 1'b1;
    end else if (r) begin
      if (stk.size() >= P) begin
        m_ret_pc[15:8] = stk.pop_back();
        m_ret_pc[7:0]  = stk.pop_back();
        nbusy = P; exp_rv = 1'b1;
      end else m_udf = 1'b1;
    end else begin
      case (o)
        ST_ADD:  if (stk.size() == D) m_ovf = 1'b1; else stk.push_back(d);
        ST_SUB:  if (stk.size() == 0) m_udf = 1'b1; else void'(stk.pop_back());
        ST_3:    if (stk.size() == 0) m_udf = 1'b1; else stk[stk.size()-1] = d;
        default: ;
      endcase
    end
  endtask

  // Steps n cycles recording busy/ret_valid; optionally drives junk requests that must be ignored.
  task automatic wait_cycles(input int n, input bit junk, output logic [7:0] btr, output logic [7:0] rtr);
    btr = 8'h00;
    rtr = 8'h00;
    for (int i = 0; i < n; i++) begin
      btr[i] = bus.busy;
      rtr[i] = bus.ret_valid;
      if (junk) begin
        bus.op       = e_stackop'($urandom_range(0, 3));
        bus.wdata    = 8'($urandom);
        bus.call_req = 1'($urandom_range(0, 1));
        bus.call_pc  = 16'($urandom);
        bus.ret_req  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({obs_status(), bus.busy, bus.ret_valid, bus.ret_pc} !== {exp_status(), 1'b0, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_state: got %h/%b/%b/%h exp %h/0/0/0000", obs_status(), bus.busy, bus.ret_valid, bus.ret_pc, exp_status());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_overflow();
    int nb; bit rv;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      apply(ST_ADD, 8'(i * 8'h11), 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
      vectors++;
      if (obs_status() !== exp_status()) begin
        miscompares++;
        $display("FAIL push_%0d: got %h exp %h", i, obs_status(), exp_status());
      end
    end
    apply(ST_ADD, 8'h55, 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
    vectors++;
    if ({bus.ovf, bus.full, bus.rdata, bus.count} !== {1'b1, 1'b1, 8'h44, 3'd4}) begin
      miscompares++;
      $display("FAIL push_full_ovf: got ovf=%b full=%b rdata=%h count=%0d exp 1 1 44 4", bus.ovf, bus.full, bus.rdata, bus.count);
    end
  endtask

  task automatic test_empty_errors();
    int nb; bit rv;
    do_reset();
    apply(ST_SUB, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
    vectors++;
    if ({bus.udf, bus.count, bus.ovf} !== {1'b1, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL pop_empty: got udf=%b count=%0d ovf=%b exp 1 0 0", bus.udf, bus.count, bus.ovf);
    end
    apply(ST_3, 8'h99, 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
    vectors++;
    if ({bus.empty, bus.rdata, bus.udf} !== {1'b1, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL replace_empty: got empty=%b rdata=%h udf=%b exp 1 00 1", bus.empty, bus.rdata, bus.udf);
    end
  endtask

  task automatic test_call_ret();
    int nb; bit rv; logic [7:0] btr, rtr;
    do_reset();
    apply(ST_ADD, 8'hAA, 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
    apply(ST_SKIP, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, nb, rv);
    wait_cycles(P, 1'b0, btr, rtr);
    vectors++;
    if ({btr, bus.busy, bus.count, bus.rdata} !== {8'h03, 1'b0, 3'd3, 8'h12}) begin
      miscompares++;
      $display("FAIL call_seq: got busytr=%h busy=%b count=%0d rdata=%h exp 03 0 3 12", btr, bus.busy, bus.count, bus.rdata);
    end
    apply(ST_SKIP, 8'h00, 1'b0, 16'h0, 1'b1, 1'b0, nb, rv);
    wait_cycles(P, 1'b0, btr, rtr);
    vectors++;
    if ({btr, rtr, bus.ret_valid, bus.ret_pc, bus.count, bus.rdata} !== {8'h03, 8'h00, 1'b1, 16'h1234, 3'd1, 8'hAA}) begin
      miscompares++;
      $display("FAIL ret_seq: got busytr=%h rvtr=%h rv=%b ret_pc=%h count=%0d rdata=%h exp 03 00 1 1234 1 aa",
               btr, rtr, bus.ret_valid, bus.ret_pc, bus.count, bus.rdata);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.ret_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ret_pulse_width: got ret_valid=%b exp 0", bus.ret_valid);
    end
  endtask

  task automatic test_rejects();
    int nb; bit rv; logic [7:0] btr, rtr;
    do_reset();
    for (int i = 0; i < 3; i++) apply(ST_ADD, 8'(8'hC0 + i), 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
    apply(ST_SKIP, 8'h00, 1'b1, 16'hBEEF, 1'b0, 1'b0, nb, rv);
    wait_cycles(P, 1'b0, btr, rtr);
    vectors++;
    if ({btr, bus.busy, bus.ovf, bus.count, bus.rdata} !== {8'h00, 1'b0, 1'b1, 3'd3, 8'hC2}) begin
      miscompares++;
      $display("FAIL call_reject: got busytr=%h busy=%b ovf=%b count=%0d rdata=%h exp 00 0 1 3 c2", btr, bus.busy, bus.ovf, bus.count, bus.rdata);
    end
    apply(ST_SUB, 8'h00, 1'b0, 16'h0, 1'b0, 1'b1, nb, rv);
    apply(ST_SUB, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
    apply(ST_SKIP, 8'h00, 1'b0, 16'h0, 1'b1, 1'b0, nb, rv);
    wait_cycles(P, 1'b0, btr, rtr);
    vectors++;
    if ({btr, rtr, bus.ret_valid, bus.udf, bus.ovf, bus.count} !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL ret_reject: got busytr=%h rvtr=%h rv=%b udf=%b ovf=%b count=%0d exp 00 00 0 1 0 1",
               btr, rtr, bus.ret_valid, bus.udf, bus.ovf, bus.count);
    end
  endtask

  task automatic test_priority();
    int nb; bit rv; logic [7:0] btr, rtr;
    do_reset();
    apply(ST_ADD, 8'h01, 1'b0, 16'h0, 1'b0, 1'b0, nb, rv);
    apply(ST_ADD, 8'h77, 1'b1, 16'hCAFE, 1'b1, 1'b0, nb, rv);
    wait_cycles(P, 1'b1, btr, rtr);
    vectors++;
    if ({btr, rtr, bus.count, bus.rdata, bus.ret_valid} !== {8'h03, 8'h00, 3'd3, 8'hCA, 1'b0}) begin
      miscompares++;
      $display("FAIL call_wins_ignore_busy: got busytr=%h rvtr=%h count=%0d rdata=%h rv=%b exp 03 00 3 ca 0",
               btr, rtr, bus.count, bus.rdata, bus.ret_valid);
    end
    do_reset();
    apply(ST_SUB, 8'h00, 1'b0, 16'h0, 1'b0, 1'b1, nb, rv);
    vectors++;
    if (bus.udf !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_vs_new_udf: got udf=%b exp 1", bus.udf);
    end
    apply(ST_SKIP, 8'h00, 1'b0, 16'h0, 1'b0, 1'b1, nb, rv);
    vectors++;
    if ({bus.udf, bus.ovf} !== 2'b00) begin
      miscompares++;
      $display("FAIL clr_err: got udf=%b ovf=%b exp 0 0", bus.udf, bus.ovf);
    end
  endtask

  task automatic test_reset_abort();
    int nb; bit rv;
    do_reset();
    apply(ST_SKIP, 8'h00, 1'b1, 16'h5A5A, 1'b0, 1'b0, nb, rv);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if ({bus.count, bus.busy, bus.ret_valid, bus.empty, bus.rdata} !== {3'd0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_abort: got count=%0d busy=%b rv=%b empty=%b rdata=%h exp 0 0 0 1 00",
               bus.count, bus.busy, bus.ret_valid, bus.empty, bus.rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int nb; bit rv; logic [7:0] btr, rtr;
    int sel; bit c, r, clr;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 9);
      c   = (sel < 2) || (sel == 9);
      r   = (sel >= 2 && sel < 4) || (sel == 9);
      clr = ($urandom_range(0, 7) == 0);
      apply(e_stackop'($urandom_range(0, 3)), 8'($urandom), c, 16'($urandom), r, clr, nb, rv);
      if (nb > 0) wait_cycles(nb, 1'b1, btr, rtr);
      else begin btr = 8'h00; rtr = 8'h00; end
      vectors++;
      if ({obs_status(), bus.busy, bus.ret_valid, bus.ret_pc} !== {exp_status(), 1'b0, rv, m_ret_pc}) begin
        miscompares++;
        $display("FAIL random_%0d: got %h/%b/%b/%h exp %h/0/%b/%h", it, obs_status(), bus.busy, bus.ret_valid,
                 bus.ret_pc, exp_status(), rv, m_ret_pc);
      end
      vectors++;
      if ({btr, rtr} !== {8'((1 << nb) - 1), 8'h00}) begin
        miscompares++;
        $display("FAIL random_busy_%0d: got busytr=%h rvtr=%h exp %h 00", it, btr, rtr, 8'((1 << nb) - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_empty_errors();
    test_call_ret();
    test_rejects();
    test_priority();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, exp completion");
    $fatal(1);
  end

endmodule
